// File: rtl/score_text_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// score_text_sequencer : character buffer for the score overlay text line.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module score_text_sequencer #(
  parameter int CHARS     = 69,
  parameter int SCORE_COL = 6,
  parameter int WORLD_COL = 26,
  parameter int LIVES_COL = 46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        update_req,
  input  logic [19:0] score,
  input  logic [3:0]  world,
  input  logic [3:0]  stage,
  input  logic [6:0]  lives,
  input  logic [7:0]  char_xy,
  output logic [7:0]  char_code,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(CHARS);
  typedef logic [AW-1:0] addr_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_CONV  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [39:0] SCORE_TXT = "SCORE";
  localparam logic [39:0] WORLD_TXT = "WORLD";
  localparam logic [39:0] LIVES_TXT = "LIVES";

  logic [2:0]  state_q, state_d;
  logic        vsync_q;
  logic        trig;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] score_bcd_q, score_bcd_d, score_adj;
  logic [19:0] score_sh_q, score_sh_d;
  logic [7:0]  lives_bcd_q, lives_bcd_d, lives_adj;
  logic [6:0]  lives_sh_q, lives_sh_d;
  logic [3:0]  world_q, world_d, stage_q, stage_d;
  logic        wr_en;
  addr_t       wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  char_code_q;
  logic [7:0]  text_q [CHARS];

  // Reset image doubles as the all-zero digit display.
  function automatic logic [7:0] template_char(input int col);
    logic [7:0] c;
    c = 8'h20;
    if (col >= 0 && col <= 4)                                c = SCORE_TXT[8*(4-col) +: 8];
    else if (col >= 20 && col <= 24)                         c = WORLD_TXT[8*(24-col) +: 8];
    else if (col >= 40 && col <= 44)                         c = LIVES_TXT[8*(44-col) +: 8];
    else if (col >= SCORE_COL && col <= SCORE_COL + 5)       c = 8'h30;
    else if (col == WORLD_COL || col == WORLD_COL + 2)       c = 8'h30;
    else if (col == WORLD_COL + 1)                           c = 8'h2D;
    else if (col == LIVES_COL + 1)                           c = 8'h30;
    return c;
  endfunction

  function automatic logic [3:0] dab(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  assign trig      = (vsync_in & ~vsync_q) | update_req;
  assign char_code = char_code_q;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trig) state_d = S_LATCH;
      S_LATCH: state_d = S_CONV;
      S_CONV:  if (cnt_q == 5'd19) state_d = S_WRITE;
      S_WRITE: if (cnt_q == 5'd9) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    wr_en = 1'b0;
    case (state_q)
      S_LATCH: busy = 1'b1;
      S_CONV:  busy = 1'b1;
      S_WRITE: begin busy = 1'b1; wr_en = 1'b1; end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    score_adj = '0;
    for (int k = 0; k < 6; k++) score_adj[4*k +: 4] = dab(score_bcd_q[4*k +: 4]);
    lives_adj = {dab(lives_bcd_q[7:4]), dab(lives_bcd_q[3:0])};
  end

  always_comb begin
    cnt_d       = cnt_q;
    score_bcd_d = score_bcd_q;
    score_sh_d  = score_sh_q;
    lives_bcd_d = lives_bcd_q;
    lives_sh_d  = lives_sh_q;
    world_d     = world_q;
    stage_d     = stage_q;
    case (state_q)
      S_LATCH: begin
        cnt_d       = '0;
        score_bcd_d = '0;
        score_sh_d  = (score > 20'd999999) ? 20'd999999 : score;
        lives_bcd_d = '0;
        lives_sh_d  = (lives > 7'd99) ? 7'd99 : lives;
        world_d     = (world > 4'd9) ? 4'd9 : world;
        stage_d     = (stage > 4'd9) ? 4'd9 : stage;
      end
      S_CONV: begin
        {score_bcd_d, score_sh_d} = {score_adj[22:0], score_sh_q, 1'b0};
        // Lives has only 7 input bits, so its engine stops after 7 steps.
        if (cnt_q < 5'd7) {lives_bcd_d, lives_sh_d} = {lives_adj[6:0], lives_sh_q, 1'b0};
        cnt_d = (cnt_q == 5'd19) ? 5'd0 : cnt_q + 5'd1;
      end
      S_WRITE: cnt_d = (cnt_q == 5'd9) ? 5'd0 : cnt_q + 5'd1;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      cnt_q       <= '0;
      score_bcd_q <= '0;
      score_sh_q  <= '0;
      lives_bcd_q <= '0;
      lives_sh_q  <= '0;
      world_q     <= '0;
      stage_q     <= '0;
    end else begin
      vsync_q     <= vsync_in;
      cnt_q       <= cnt_d;
      score_bcd_q <= score_bcd_d;
      score_sh_q  <= score_sh_d;
      lives_bcd_q <= lives_bcd_d;
      lives_sh_q  <= lives_sh_d;
      world_q     <= world_d;
      stage_q     <= stage_d;
    end
  end

  always_comb begin
    wr_addr = '0;
    wr_data = 8'h20;
    case (cnt_q)
      5'd0: begin wr_addr = addr_t'(SCORE_COL);     wr_data = ascii(score_bcd_q[23:20]); end
      5'd1: begin wr_addr = addr_t'(SCORE_COL + 1); wr_data = ascii(score_bcd_q[19:16]); end
      5'd2: begin wr_addr = addr_t'(SCORE_COL + 2); wr_data = ascii(score_bcd_q[15:12]); end
      5'd3: begin wr_addr = addr_t'(SCORE_COL + 3); wr_data = ascii(score_bcd_q[11:8]);  end
      5'd4: begin wr_addr = addr_t'(SCORE_COL + 4); wr_data = ascii(score_bcd_q[7:4]);   end
      5'd5: begin wr_addr = addr_t'(SCORE_COL + 5); wr_data = ascii(score_bcd_q[3:0]);   end
      5'd6: begin wr_addr = addr_t'(WORLD_COL);     wr_data = ascii(world_q);            end
      5'd7: begin wr_addr = addr_t'(WORLD_COL + 2); wr_data = ascii(stage_q);            end
      5'd8: begin
        wr_addr = addr_t'(LIVES_COL);
        wr_data = (lives_bcd_q[7:4] == 4'd0) ? 8'h20 : ascii(lives_bcd_q[7:4]);
      end
      5'd9: begin wr_addr = addr_t'(LIVES_COL + 1); wr_data = ascii(lives_bcd_q[3:0]);   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHARS; i++) text_q[i] <= template_char(i);
    end else if (wr_en) begin
      text_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         char_code_q <= 8'h20;
    else if (char_xy < 8'(CHARS))    char_code_q <= text_q[char_xy[AW-1:0]];
    else                             char_code_q <= 8'h20;
  end

endmodule
`default_nettype wire

// File: tb/tb_score_text_sequencer.sv
`default_nettype none
// Scoreboard bench for score_text_sequencer: stimulus queues expectations
// tagged with the cycle they are due; a monitor compares at each negedge.
module tb_score_text_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync_in, update_req;
  logic [19:0] score;
  logic [3:0]  world, stage;
  logic [6:0]  lives;
  logic [7:0]  char_xy;
  logic [7:0]  char_code;
  logic        busy, done;

  score_text_sequencer dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .update_req(update_req),
    .score(score), .world(world), .stage(stage), .lives(lives),
    .char_xy(char_xy), .char_code(char_code), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] val; int tag; } exp_t;
  exp_t char_q[$];
  exp_t busy_q[$];
  int   done_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] exp_line [69];

  task automatic check8(input string name, input int tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s tag=%0d cycle=%0d got=%h exp=%h", name, tag, cyc, got, exp);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (char_q.size() > 0 && char_q[0].cyc <= cyc) begin
        e = char_q.pop_front();
        if (e.cyc < cyc) check8("char_code_missed", e.tag, 8'hxx, e.val);
        else             check8("char_code", e.tag, char_code, e.val);
      end
      while (busy_q.size() > 0 && busy_q[0].cyc <= cyc) begin
        e = busy_q.pop_front();
        if (e.cyc < cyc) check8("busy_missed", e.tag, 8'hxx, e.val);
        else             check8("busy", e.tag, {7'd0, busy}, e.val);
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        void'(done_q.pop_front());
        check8("done_pulse", cyc, {7'd0, done}, 8'd1);
      end else if (done === 1'b1) begin
        check8("done_unexpected", cyc, {7'd0, done}, 8'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic set_str(input int col, input string s);
    for (int i = 0; i < s.len(); i++) exp_line[col + i] = s[i];
  endtask

  task automatic model_template();
    for (int i = 0; i < 69; i++) exp_line[i] = 8'h20;
    set_str(0, "SCORE");  set_str(6, "000000");
    set_str(20, "WORLD"); set_str(26, "0-0");
    set_str(40, "LIVES"); set_str(46, " 0");
  endtask

  task automatic read_col(input int idx, input logic [7:0] e);
    char_xy = 8'(idx);
    char_q.push_back('{cyc + 1, e, idx});
    @(negedge clk);
  endtask

  task automatic sweep();
    for (int c = 0; c < 69; c++) read_col(c, exp_line[c]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a trigger at the current negedge (cycle n); returns at n+2.
  task automatic start_update(input bit via_vsync, input bit completes);
    int n;
    n = cyc;
    busy_q.push_back('{n + 1, 8'd1, 1});
    if (completes) begin
      busy_q.push_back('{n + 31, 8'd1, 31});
      busy_q.push_back('{n + 32, 8'd0, 32});
      done_q.push_back(n + 32);
    end
    if (via_vsync) vsync_in = 1'b1;
    else           update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    @(negedge clk);
    vsync_in = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; vsync_in = 1'b0; update_req = 1'b0;
    score = '0; world = '0; stage = '0; lives = '0; char_xy = 8'd0;
    model_template();
    wait_cycles(3);
    busy_q.push_back('{cyc + 1, 8'd0, 0});
    char_q.push_back('{cyc + 1, 8'h20, 0});
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset template and out-of-range reads
    sweep();
    read_col(200, 8'h20);
    read_col(69, 8'h20);

    // Basic update via vsync
    score = 20'd123456; world = 4'd1; stage = 4'd2; lives = 7'd5;
    start_update(1'b1, 1'b1);
    wait_cycles(31);
    set_str(6, "123456"); set_str(26, "1-2"); set_str(46, " 5");
    sweep();

    // Clamping via update_req
    score = 20'hFFFFF; lives = 7'd127; world = 4'd12;
    start_update(1'b0, 1'b1);
    wait_cycles(31);
    set_str(6, "999999"); set_str(26, "9-2"); set_str(46, "99");
    sweep();

    // Triggers during CONV dropped, inputs changed after LATCH ignored
    score = 20'd654321; world = 4'd3; stage = 4'd4; lives = 7'd42;
    start_update(1'b1, 1'b1);
    score = 20'd111111; world = 4'd5; stage = 4'd6; lives = 7'd77;
    wait_cycles(3);
    vsync_in = 1'b1;
    wait_cycles(2);
    vsync_in = 1'b0;
    wait_cycles(3);
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    wait_cycles(22);
    set_str(6, "654321"); set_str(26, "3-4"); set_str(46, "42");
    sweep();

    // Reset after three score digits have been written
    score = 20'd987654; world = 4'd7; stage = 4'd8; lives = 7'd33;
    n = cyc;
    start_update(1'b0, 1'b0);
    wait_cycles(21);
    read_col(6, 8'h39);
    @(negedge clk);
    #1 rst = 1'b1;
    busy_q.push_back('{n + 26, 8'd0, 99});
    char_q.push_back('{n + 26, 8'h20, 99});
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    model_template();
    sweep();

    // Normal completion after the abort; lives 10 then 0
    score = 20'd7; world = 4'd0; stage = 4'd9; lives = 7'd10;
    start_update(1'b1, 1'b1);
    wait_cycles(31);
    set_str(6, "000007"); set_str(26, "0-9"); set_str(46, "10");
    sweep();

    lives = 7'd0;
    start_update(1'b0, 1'b1);
    wait_cycles(31);
    set_str(46, " 0");
    sweep();

    wait_cycles(3);
    #1;
    n_checks++;
    if (char_q.size() + busy_q.size() + done_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations got=%0d exp=0", char_q.size() + busy_q.size() + done_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_text_sequencer.md
Name: score_text_sequencer

Overview:
- Owns the 69-character text line drawn by the score overlay: an 8-pixel-wide font over a 552-pixel line.
- At each frame start it latches the game counters (score, world, stage, lives).
- It converts them to decimal with a sequential double-dabble engine and writes the ASCII digits into an internal character buffer.
- It serves character-code lookups from the overlay's char_xy index; the code feeds the font ROM.

Parameters:
- CHARS, 69: buffer depth in characters; valid char_xy range is 0..CHARS-1.
- SCORE_COL, 6: column of the most-significant score digit (6 digits).
- WORLD_COL, 26: column of the world digit; '-' at +1, stage digit at +2.
- LIVES_COL, 46: column of the tens digit of lives (2 digits).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- vsync_in  in  1  vertical sync from the timing chain; a rising edge starts an update
- update_req  in  1  single-cycle forced-update request
- score  in  20  binary score
- world  in  4  binary world number
- stage  in  4  binary stage number
- lives  in  7  binary lives count
- char_xy  in  8  character index requested by the overlay
- char_code  out  8  ASCII code at char_xy; registered
- busy  out  1  high while an update is in progress
- done  out  1  one-cycle pulse when the buffer update completes

Interface note: reset rst, asynchronous, active-high; clock clk. All state is in the clk domain.

Behaviour:
- Template text, written at reset:
  - "SCORE" at columns 0-4
  - "WORLD" at 20-24
  - "LIVES" at 40-44
  - '-' at WORLD_COL+1
  - every other column 0x20 (space)
- Reset state:
  - Digit fields: score "000000", world '0', stage '0', lives " 0".
  - char_code=0x20, busy=0, done=0, FSM=IDLE.
- Read port:
  - char_code <= buf[char_xy] one clk after char_xy is presented.
  - char_xy >= CHARS returns 0x20.
  - Reads are never stalled by writes. A read of a column written in the same cycle returns the old value.
- Trigger:
  - Start condition: vsync_in rising edge (registered previous value; reset value 0) OR update_req, while in IDLE.
  - Triggers arriving while busy=1 are dropped, not queued.
- FSM:
  - IDLE -> LATCH on trigger.
  - LATCH (1 cycle): capture the four inputs; busy=1.
    - score > 999999 clamps to 999999.
    - lives > 99 clamps to 99.
    - world and stage > 9 clamp to 9.
  - CONV (20 cycles):
    - Score engine: 24-bit BCD register plus 20-bit shift register. Each cycle, add 3 to every nibble >= 5, then shift left 1.
    - Lives engine: 8-bit BCD register. It runs the same step for its first 7 cycles, then holds.
    - Bit counter 0..19; exit CONV when the counter reaches 19.
  - WRITE (10 cycles): one buffer write per cycle, in this order:
    - score digits MSB to LSB at SCORE_COL..SCORE_COL+5
    - world at WORLD_COL, stage at WORLD_COL+2
    - lives tens at LIVES_COL, lives units at LIVES_COL+1
  - Digit encoding:
    - ASCII 0x30+d.
    - Score keeps leading zeros.
    - A lives tens digit of 0 is written as 0x20.
  - FIN (1 cycle): done=1, busy=0 -> IDLE.
- Latency: trigger edge to done pulse is 32 cycles. This is well inside any vertical blanking interval.
- Latched values are stable during CONV/WRITE; input changes after LATCH affect only the next update.
- Reset mid-operation:
  - Aborts immediately.
  - The buffer returns to the reset template; no partial digits survive.
  - done does not pulse.

Test Plan:
- Reset, then sweep char_xy 0..68 -> "SCORE" at 0-4, "000000" at 6-11, "WORLD" at 20-24, "0-0" at 26-28, "LIVES" at 40-44, " 0" at 46-47, 0x20 elsewhere; char_xy=200 -> 0x20; each read 1-cycle latency.
- score=123456, world=1, stage=2, lives=5, vsync_in rising -> busy for 31 cycles, done at cycle 32 after the edge. Columns 6-11 read "123456", 26-28 "1-2", 46-47 " 5".
- score=20'hFFFFF (1048575), lives=127, world=12 via update_req -> "999999", lives "99", world '9'.
- Second vsync edge and update_req during CONV -> ignored. Exactly one done pulse; buffer reflects the first latched values even though inputs changed after LATCH.
- Assert rst during WRITE after 3 score digits have been written -> buffer back to the template with "000000"; busy=0, no done pulse; the next trigger completes normally.
- lives=10, then a later update with lives=0 -> "10", then " 0"; score=7 -> "000007".
